uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter; the transmit end of the UART link whose receiver shares the same oversampling clock and configuration. It accepts an 8-bit word through a valid/busy handshake and serialises it as start bit, 8 data bits LSB first, optional parity bit and one stop bit. Each bit lasts PRESCALE clock cycles, so both ends of the link run from the same clock and the same PRESCALE/PAR_EN/PAR_TYP settings.

## Interface
- No parameters. Data width is fixed at 8 bits; PRESCALE is fixed at 6 bits.
- CLK  in  1  Single clock (oversampling clock, same as receiver).
- RST  in  1  Reset. Asynchronous, active-high.
- P_DATA  in  8  Parallel word to transmit.
- DATA_VALID  in  1  Transmit request. Sampled only while the block is idle.
- PAR_EN  in  1  1 = parity bit inserted.
- PAR_TYP  in  1  Parity type: 0 = even, 1 = odd.
- PRESCALE  in  6  Clock cycles per bit. Nominal values are 8, 16 and 32.
- TX_OUT  out  1  Serial line. Idles high.
- BUSY  out  1  High while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - TX_OUT=1, BUSY=0.
  - If DATA_VALID=1 on a rising edge, the block accepts the request on that edge.
  - On acceptance it latches P_DATA, PAR_EN, PAR_TYP and PRESCALE into internal registers.
  - The parity bit is computed at acceptance: even = XOR of the 8 data bits; odd = inverted XOR.
  - Next state is START.
- START: TX_OUT=0 for one bit period, then DATA.
- DATA
  - Bit index counts 0 to 7; TX_OUT = latched data[index], LSB first.
  - After index 7 completes, go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
- PARITY: TX_OUT = latched parity bit for one bit period, then STOP.
- STOP: TX_OUT=1 for one bit period, then IDLE.
- Bit period counter
  - 6-bit counter runs 0 to PRESCALE_latched−1 and wraps to 0 at the end of each bit.
  - The terminal compare is done in 6-bit arithmetic. PRESCALE=0 therefore gives a 64-cycle bit; PRESCALE=1 gives a 1-cycle bit.
- Frame length
  - 11 × PRESCALE cycles with parity.
  - 10 × PRESCALE cycles without parity.
- Changes on P_DATA, PAR_EN, PAR_TYP, PRESCALE or DATA_VALID during a frame have no effect. Only the latched values are used.
- A DATA_VALID pulse that arrives while BUSY=1 is dropped. The block has no queue.
- TX_OUT and BUSY are driven directly from registers (no combinational output path, glitch-free).

## Timing
- Reset
  - Asserting RST immediately forces the state to IDLE, TX_OUT=1, BUSY=0, and clears all counters and latches.
  - This applies mid-frame too: the line returns high at once, and the frame is abandoned and is not resumed.
- Acceptance latency
  - The request is accepted on edge k (state IDLE, DATA_VALID=1).
  - TX_OUT=0 and BUSY=1 are valid from edge k onward, i.e. visible in the cycle after edge k.
- Bit boundaries: each bit occupies exactly PRESCALE cycles, starting at edge k + n·PRESCALE.
- End of frame
  - On the edge that ends the stop bit, the state returns to IDLE and BUSY falls to 0. TX_OUT stays 1.
- Back-to-back frames
  - If DATA_VALID is held high, the next frame is accepted on the first edge seen in IDLE.
  - This leaves exactly one extra idle cycle (TX_OUT=1) between frames, so the stop bit plus gap is PRESCALE+1 cycles.
- BUSY high time per frame: exactly 11·PRESCALE cycles with parity, 10·PRESCALE cycles without.

## Test plan
- **Even parity, PRESCALE=8, P_DATA=0xAA, one-cycle DATA_VALID**
  - TX_OUT, per 8-cycle bit: 0 | 0,1,0,1,0,1,0,1 | 0 | 1.
  - BUSY high for 88 cycles.
  - Loopback into the receiver gives P_DATA=0xAA with no parity or stop error.
- **Odd parity, PRESCALE=16, P_DATA=0xAA**
  - Parity bit=1; otherwise the same bit sequence.
  - BUSY high for 176 cycles.
- **No parity, PRESCALE=32, P_DATA=0x5A**
  - 10 bits: 0 | 0,1,0,1,1,0,1,0 | 1.
  - BUSY high for 320 cycles.
- **Back-to-back, PRESCALE=8, even parity, DATA_VALID held high, P_DATA=0xAA then 0xEA**
  - Two frames separated by exactly one idle cycle.
  - Second frame: data bits 0,1,0,1,0,1,1,1 and parity 1.
- **Mid-frame changes, PRESCALE=8, P_DATA=0x0F accepted**
  - During data bit 2, drive P_DATA=0xFF, PRESCALE=16, PAR_EN=0 and pulse DATA_VALID.
  - Required: frame stays 0x0F with 8-cycle bits and parity, and no second frame follows.
- **Reset mid-frame, PRESCALE=16**
  - Assert RST during data bit 4.
  - Required: TX_OUT=1 and BUSY=0 without waiting for a clock edge.
  - After release, a new request for 0x33 transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
//==============================================================================
// Module   : uart_tx
// Brief    : 8N1/8E1/8O1 UART transmitter, bit period = PRESCALE clocks.
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] P_DATA,
   input  logic       DATA_VALID,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic [5:0] PRESCALE,
   output logic       TX_OUT,
   output logic       BUSY
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_data;
   logic        r_par_en;
   logic        r_par_bit;
   logic [5:0]  r_prescale;
   logic [5:0]  r_bit_cnt;
   logic [5:0]  w_bit_cnt_nxt;
   logic [2:0]  r_idx;
   logic [2:0]  w_idx_nxt;
   logic [2:0]  w_idx_inc;
   logic        r_tx;
   logic        w_tx_nxt;
   logic        r_busy;
   logic        w_busy_nxt;
   logic        w_accept;
   logic        w_bit_end;

   // 6-bit wrap makes PRESCALE=0 a 64-cycle bit
   assign w_bit_end = (r_bit_cnt == (r_prescale - 6'd1));
   assign w_idx_inc = r_idx + 3'd1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_data     <= 8'd0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_prescale <= 6'd0;
         r_bit_cnt  <= 6'd0;
         r_idx      <= 3'd0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= w_busy_nxt;
         if (w_accept) begin
            r_data     <= P_DATA;
            r_par_en   <= PAR_EN;
            r_par_bit  <= (^P_DATA) ^ PAR_TYP;
            r_prescale <= PRESCALE;
         end
      end
   end

   // Next-state logic computes the value the line takes after the edge,
   // so TX_OUT and BUSY come straight from flops.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_idx_nxt     = r_idx;
      w_tx_nxt      = r_tx;
      w_busy_nxt    = r_busy;
      w_accept      = 1'b0;

      if (r_state == S_IDLE) begin
         w_tx_nxt      = 1'b1;
         w_busy_nxt    = 1'b0;
         w_bit_cnt_nxt = 6'd0;
         w_idx_nxt     = 3'd0;
         if (DATA_VALID) begin
            w_accept    = 1'b1;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
         end
      end else if (!w_bit_end) begin
         w_bit_cnt_nxt = r_bit_cnt + 6'd1;
      end else begin
         w_bit_cnt_nxt = 6'd0;
         case (r_state)
            S_START: begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = 3'd0;
               w_tx_nxt    = r_data[0];
            end
            S_DATA: begin
               if (r_idx == 3'd7) begin
                  if (r_par_en) begin
                     w_state_nxt = S_PARITY;
                     w_tx_nxt    = r_par_bit;
                  end else begin
                     w_state_nxt = S_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_idx_nxt = w_idx_inc;
                  w_tx_nxt  = r_data[w_idx_inc];
               end
            end
            S_PARITY: begin
               w_state_nxt = S_STOP;
               w_tx_nxt    = 1'b1;
            end
            S_STOP: begin
               w_state_nxt = S_IDLE;
               w_tx_nxt    = 1'b1;
               w_busy_nxt  = 1'b0;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_tx_nxt    = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   assign TX_OUT = r_tx;
   assign BUSY   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//==============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx: directed table, corner cases,
//            randomized frames against a bit-list reference model.
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

   logic       CLK_tb = 1'b0;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic [5:0] prescale;
   logic       tx_out;
   logic       busy;

   always #5 CLK_tb = ~CLK_tb;

   uart_tx dut (
      .CLK        (CLK_tb),
      .RST        (rst),
      .P_DATA     (p_data),
      .DATA_VALID (data_valid),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .PRESCALE   (prescale),
      .TX_OUT     (tx_out),
      .BUSY       (busy)
   );

   typedef struct {
      logic [7:0]  data;
      logic        pe;
      logic        pt;
      logic [5:0]  ps;
      logic [10:0] seq;     // bits in transmit order, leftmost first
      int          nbits;
      int          busy_cycles;
   } vec_t;

   vec_t vecs[6];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   exp_q[$];
   int   exp_pe;

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference frame: start, data LSB first, optional parity, stop
   function automatic void model(input logic [7:0] d, input logic pe,
                                 input logic pt, input logic [5:0] ps);
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      if (pe) exp_q.push_back((($countones(d) % 2) == 1) ^ pt);
      exp_q.push_back(1'b1);
      exp_pe = (ps == 6'd0) ? 64 : int'(ps);
   endfunction

   task automatic request(input logic [7:0] d, input logic pe,
                          input logic pt, input logic [5:0] ps);
      @(negedge CLK_tb);
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
      prescale   = ps;
      data_valid = 1'b1;
      @(posedge CLK_tb);
      #1;
   endtask

   // Entered 1 time unit after the acceptance edge; follows the frame until BUSY drops
   task automatic watch_frame(input string name, input int exp_busy,
                              input bit noise, input int poke_at);
      int c;
      int bad;
      int idx;
      bit e;
      c   = 0;
      bad = -1;
      while (busy === 1'b1 && c < exp_busy + 70) begin
         idx = c / exp_pe;
         e   = (idx < exp_q.size()) ? exp_q[idx] : 1'b1;
         if (tx_out !== e && bad < 0) bad = c;
         if (noise) begin
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            prescale   = 6'($urandom);
            data_valid = 1'($urandom);
         end
         if (c == poke_at) begin
            p_data     = 8'hFF;
            prescale   = 6'd16;
            par_en     = 1'b0;
            data_valid = 1'b1;
         end
         if (poke_at >= 0 && c == poke_at + 1) data_valid = 1'b0;
         c++;
         @(posedge CLK_tb);
         #1;
      end
      if (noise) data_valid = 1'b0;
      check_int({name, " first bad tx cycle"}, bad, -1);
      check_int({name, " busy cycles"}, c, exp_busy);
      check_int({name, " idle tx"}, int'(tx_out), 1);
   endtask

   initial begin
      int highs;
      vecs[0] = '{8'hAA, 1'b1, 1'b0, 6'd8,  11'b00101010101, 11, 88};
      vecs[1] = '{8'hAA, 1'b1, 1'b1, 6'd16, 11'b00101010111, 11, 176};
      vecs[2] = '{8'h5A, 1'b0, 1'b0, 6'd32, 11'b00010110101, 10, 320};
      vecs[3] = '{8'hEA, 1'b1, 1'b0, 6'd8,  11'b00101011111, 11, 88};
      vecs[4] = '{8'h0F, 1'b1, 1'b0, 6'd1,  11'b01111000001, 11, 11};
      vecs[5] = '{8'h01, 1'b0, 1'b0, 6'd0,  11'b00100000001, 10, 640};

      rst        = 1'b1;
      p_data     = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      prescale   = 6'd8;
      #2;
      check_int("reset tx before clock", int'(tx_out), 1);
      check_int("reset busy before clock", int'(busy), 0);
      data_valid = 1'b1;
      repeat (3) @(posedge CLK_tb);
      #1;
      check_int("reset holds idle", int'(busy), 0);
      @(negedge CLK_tb);
      data_valid = 1'b0;
      rst        = 1'b0;
      repeat (2) @(posedge CLK_tb);

      for (int i = 0; i < 6; i++) begin
         request(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ps);
         data_valid = 1'b0;
         exp_q.delete();
         for (int b = 0; b < vecs[i].nbits; b++)
            exp_q.push_back(vecs[i].seq[vecs[i].nbits - 1 - b]);
         exp_pe = (vecs[i].ps == 6'd0) ? 64 : int'(vecs[i].ps);
         watch_frame($sformatf("vec%0d", i), vecs[i].busy_cycles, 1'b0, -1);
         repeat (2) @(posedge CLK_tb);
      end

      // Back-to-back with DATA_VALID held high
      model(8'hAA, 1'b1, 1'b0, 6'd8);
      request(8'hAA, 1'b1, 1'b0, 6'd8);
      p_data = 8'hEA;
      watch_frame("b2b first", 88, 1'b0, -1);
      check_int("b2b gap busy", int'(busy), 0);
      @(posedge CLK_tb);
      #1;
      data_valid = 1'b0;
      model(8'hEA, 1'b1, 1'b0, 6'd8);
      watch_frame("b2b second", 88, 1'b0, -1);

      // Inputs changed and a request pulsed during data bit 2
      @(posedge CLK_tb);
      model(8'h0F, 1'b1, 1'b0, 6'd8);
      request(8'h0F, 1'b1, 1'b0, 6'd8);
      data_valid = 1'b0;
      watch_frame("midframe", 88, 1'b0, 3 * 8 + 2);
      highs = 0;
      repeat (40) begin
         @(posedge CLK_tb);
         #1;
         if (busy === 1'b1) highs++;
      end
      check_int("midframe no second frame", highs, 0);

      // Asynchronous reset during data bit 4
      request(8'hC3, 1'b1, 1'b0, 6'd16);
      data_valid = 1'b0;
      repeat (83) @(posedge CLK_tb);
      #3;
      check_int("pre-reset data bit4", int'(tx_out), 0);
      rst = 1'b1;
      #1;
      check_int("async reset tx", int'(tx_out), 1);
      check_int("async reset busy", int'(busy), 0);
      repeat (3) @(posedge CLK_tb);
      #1;
      check_int("reset abandons frame", int'(busy), 0);
      @(negedge CLK_tb);
      rst = 1'b0;
      model(8'h33, 1'b1, 1'b1, 6'd16);
      request(8'h33, 1'b1, 1'b1, 6'd16);
      data_valid = 1'b0;
      watch_frame("after reset", 176, 1'b0, -1);

      // Randomized frames with input noise during every frame
      for (int n = 0; n < 25; n++) begin
         logic [7:0] d;
         logic       pe;
         logic       pt;
         logic [5:0] ps;
         d  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         ps = 6'($urandom_range(1, 12));
         model(d, pe, pt, ps);
         request(d, pe, pt, ps);
         data_valid = 1'b0;
         watch_frame($sformatf("rand%0d", n), (pe ? 11 : 10) * int'(ps), 1'b1, -1);
         repeat ($urandom_range(0, 3)) @(posedge CLK_tb);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
